// File: rtl/jtag_chain_sequencer_if.sv
// Command/response bundle between a bus master and the JTAG chain sequencer.
interface jtag_chain_sequencer_if #(parameter int MAX_LEN = 32);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [5:0]         cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic [MAX_LEN-1:0] rsp_data;
   logic               rsp_err;

   modport master (output cmd_valid, cmd_op, cmd_len, cmd_data,
                   input  cmd_ready, rsp_valid, rsp_data, rsp_err);
   modport slave  (input  cmd_valid, cmd_op, cmd_len, cmd_data,
                   output cmd_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/jtag_chain_sequencer.sv
// JTAG host: turns TAP-reset / IR / DR / run-idle commands into TCK/TMS/TDI
// sequences, captures TDO while shifting, and always parks the TAP in RTI.
module jtag_chain_sequencer #(
   parameter int MAX_LEN = 32,
   parameter int CLK_DIV = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   jtag_chain_sequencer_if.slave  bus,
   output logic                   TCK,
   output logic                   TMS,
   output logic                   TDI,
   output logic                   TRST,
   input  logic                   TDO
);
   localparam int CW = $clog2(MAX_LEN + 1);
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, TLR, PRE, SHIFT, POST, RUN, RSP} state_t;

   state_t             state, state_n;
   logic [5:0]         step, step_n;
   logic [CW-1:0]      bit_cnt, bit_n;
   logic [1:0]         op, op_v;
   logic [5:0]         len, len_v;
   logic [MAX_LEN-1:0] data, data_v, cap;
   logic [DW-1:0]      div_cnt;
   logic               init_done, accept, tick, pend, load, in_tck;
   logic               tms_n, tdi_n, bad_len;

   assign bus.cmd_ready = (state == IDLE) && init_done;
   assign bus.rsp_valid = (state == RSP);
   assign accept  = bus.cmd_valid && bus.cmd_ready;
   assign in_tck  = state inside {TLR, PRE, SHIFT, POST, RUN};
   assign tick    = (div_cnt == DW'(CLK_DIV - 1));
   assign pend    = in_tck && tick && TCK;   // last clk of a TCK high phase
   assign bad_len = (bus.cmd_len == 6'd0) || (int'(bus.cmd_len) > MAX_LEN);

   // While accepting, the first TCK's TMS/TDI must come from the bus fields
   assign op_v   = (state == IDLE) ? bus.cmd_op   : op;
   assign len_v  = (state == IDLE) ? bus.cmd_len  : len;
   assign data_v = (state == IDLE) ? bus.cmd_data : data;

   always_comb begin
      state_n = state;
      step_n  = step;
      bit_n   = bit_cnt;
      load    = 1'b0;
      case (state)
         IDLE: begin
            step_n = '0;
            bit_n  = '0;
            if (accept) begin
               case (bus.cmd_op)
                  2'b00:   state_n = TLR;
                  2'b11:   state_n = (bus.cmd_len == 6'd0) ? RSP : RUN;
                  default: state_n = bad_len ? RSP : PRE;
               endcase
            end else if (!init_done && TRST) begin
               state_n = TLR;
            end
            load = (state_n != IDLE) && (state_n != RSP);
         end
         TLR: if (pend) begin
            if (step == 6'd5) state_n = RSP;
            else begin step_n = step + 6'd1; load = 1'b1; end
         end
         PRE: if (pend) begin
            load = 1'b1;
            if (step == ((op == 2'b01) ? 6'd3 : 6'd2)) begin
               state_n = SHIFT;
               bit_n   = '0;
            end else step_n = step + 6'd1;
         end
         SHIFT: if (pend) begin
            load = 1'b1;
            if (int'(bit_cnt) == int'(len) - 1) begin
               state_n = POST;
               step_n  = '0;
            end else bit_n = bit_cnt + CW'(1);
         end
         POST: if (pend) begin
            if (step == 6'd1) state_n = RSP;
            else begin step_n = step + 6'd1; load = 1'b1; end
         end
         RUN: if (pend) begin
            if (step == len - 6'd1) state_n = RSP;
            else begin step_n = step + 6'd1; load = 1'b1; end
         end
         RSP:     state_n = IDLE;
         default: state_n = IDLE;
      endcase

      // TMS/TDI for the TCK period that starts on this edge
      tms_n = 1'b0;
      tdi_n = 1'b0;
      case (state_n)
         TLR:   tms_n = (step_n != 6'd5);
         PRE:   tms_n = (op_v == 2'b01) ? (step_n < 6'd2) : (step_n == 6'd0);
         SHIFT: begin
            tms_n = (int'(bit_n) == int'(len_v) - 1);
            tdi_n = data_v[bit_n[IW-1:0]];
         end
         POST:  tms_n = (step_n == 6'd0);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         step         <= '0;
         bit_cnt      <= '0;
         op           <= '0;
         len          <= '0;
         data         <= '0;
         cap          <= '0;
         div_cnt      <= '0;
         init_done    <= 1'b0;
         TCK          <= 1'b0;
         TMS          <= 1'b1;
         TDI          <= 1'b0;
         TRST         <= 1'b0;
         bus.rsp_data <= '0;
         bus.rsp_err  <= 1'b0;
      end else begin
         state   <= state_n;
         step    <= step_n;
         bit_cnt <= bit_n;
         TRST    <= 1'b1;
         if (accept) begin
            op   <= bus.cmd_op;
            len  <= bus.cmd_len;
            data <= bus.cmd_data;
            cap  <= '0;
         end
         if (load) begin
            TMS <= tms_n;
            TDI <= tdi_n;
         end
         if (in_tck) begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) TCK <= ~TCK;
            // TDO sampled on the clk edge that raises TCK
            if (tick && !TCK && state == SHIFT) cap[bit_cnt[IW-1:0]] <= TDO;
         end else begin
            div_cnt <= '0;
            TCK     <= 1'b0;
         end
         if (state == RSP) init_done <= 1'b1;
         if (state_n == RSP && state != RSP) begin
            if (state == IDLE) begin
               bus.rsp_data <= '0;
               bus.rsp_err  <= bus.cmd_op[0] ^ bus.cmd_op[1];
            end else begin
               bus.rsp_data <= cap;
               bus.rsp_err  <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_jtag_chain_sequencer.sv
// Randomized scoreboard bench: a behavioural TAP + delay-chain partner drives
// TDO; expected responses come from a bit-stream model of the chain.
module tb_jtag_chain_sequencer;
   localparam int MAX_LEN = 32;
   localparam int CLK_DIV = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic tck, tms, tdi, trst, tdo;

   always #5 clk = ~clk;

   jtag_chain_sequencer_if #(.MAX_LEN(MAX_LEN)) bus();

   jtag_chain_sequencer #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .TCK(tck), .TMS(tms), .TDI(tdi), .TRST(trst), .TDO(tdo));

   typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                     SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_t;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [31:0] ntck;
      logic [63:0] tmsp;
   } exp_t;

   int          checks = 0;
   int          passes = 0;
   exp_t        sb[$];
   tap_t        tap = TLR;
   int          ntck_total = 0;
   int          tdi_bad = 0;
   logic        tms_q[$];
   int          dly = 0;
   logic [7:0]  sr = '0;
   logic [63:0] chain_c = '0;

   // dly=0: straight loopback; otherwise a dly-bit shift chain
   assign tdo = (dly == 0) ? tdi : sr[0];

   function automatic tap_t tap_next(tap_t s, logic m);
      case (s)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PDR;
         PDR:   return m ? EX2DR : PDR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR:  return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PIR;
         PIR:   return m ? EX2IR : PIR;
         EX2IR: return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   function automatic logic [63:0] mask(int n);
      return (64'd1 << n) - 64'd1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference: TMS pattern, TCK count and captured stream from the command rules
   task automatic model(input logic [1:0] op, input logic [5:0] l, input logic [31:0] d,
                        output exp_t e);
      int pre;
      logic [63:0] s;
      e = '0;
      case (op)
         2'b00: begin e.ntck = 6; e.tmsp = 64'h1F; end
         2'b11: begin e.ntck = 32'(l); e.tmsp = '0; end
         default: begin
            if (l == 0 || int'(l) > MAX_LEN) e.err = 1'b1;
            else begin
               pre    = (op == 2'b01) ? 4 : 3;
               e.ntck = 32'(int'(l) + pre + 2);
               e.tmsp = ((op == 2'b01) ? 64'b0011 : 64'b001)
                      | (64'd1 << (pre + int'(l) - 1)) | (64'd1 << (pre + int'(l)));
               s       = chain_c | (({32'b0, d} & mask(int'(l))) << dly);
               e.data  = 32'(s & mask(int'(l)));
               chain_c = (s >> l) & mask(dly);
            end
         end
      endcase
   endtask

   task automatic tck_mon();
      logic [7:0] t;
      forever begin
         @(posedge tck or negedge trst);
         if (!trst) tap = TLR;
         else if (tck) begin
            if (tap == SHDR || tap == SHIR) begin
               if (dly != 0) begin
                  t = sr >> 1;
                  t[dly-1] = tdi;
                  sr = t;
               end
            end else if (tdi !== 1'b0) tdi_bad++;
            tms_q.push_back(tms);
            ntck_total++;
            tap = tap_next(tap, tms);
         end
      end
   endtask

   task automatic monitor();
      int base = 0;
      int tdi_base = 0;
      int n;
      logic [63:0] pat;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            base     = ntck_total;
            tdi_base = tdi_bad;
         end else if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_rsp: got rsp_valid expected none");
            end else begin
               e = sb.pop_front();
               n = ntck_total - base;
               pat = '0;
               for (int k = 0; k < n && k < 64; k++) pat[k] = tms_q[base + k];
               chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
               chk("rsp_err",  64'(bus.rsp_err),  64'(e.err));
               chk("tck_count", 64'(n), 64'(e.ntck));
               chk("tms_pattern", pat, e.tmsp);
               chk("tap_in_rti", 64'(int'(tap)), 64'(int'(RTI)));
               chk("tdi_quiet", 64'(tdi_bad - tdi_base), 64'd0);
               base     = ntck_total;
               tdi_base = tdi_bad;
            end
         end
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [5:0] l, input logic [31:0] d);
      exp_t e;
      bit ok = 1'b0;
      for (int i = 0; i < 4000 && !ok; i++) begin
         @(negedge clk);
         ok = bus.cmd_ready;
      end
      if (!ok) begin
         checks++;
         $display("FAIL cmd_ready_timeout: got 0 expected 1");
         return;
      end
      model(op, l, d, e);
      sb.push_back(e);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_len   = l;
      bus.cmd_data  = d;
      @(posedge clk); #1;
      // junk held while busy must be ignored
      bus.cmd_op   = 2'($urandom);
      bus.cmd_len  = 6'($urandom);
      bus.cmd_data = $urandom;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 6000 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic rand_cmd();
      logic [1:0] op;
      logic [5:0] l;
      int r;
      op = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      if (op == 2'b11) l = 6'($urandom_range(0, 12));
      else if (r == 0) l = 6'd0;
      else if (r == 1) l = 6'($urandom_range(33, 63));
      else l = 6'($urandom_range(1, 32));
      send(op, l, $urandom);
   endtask

   exp_t init_e;

   initial begin
      int n0;
      bit ok;
      init_e = '{data: '0, err: 1'b0, ntck: 32'd6, tmsp: 64'h1F};
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      fork
         monitor();
         tck_mon();
      join_none

      repeat (3) @(posedge clk); #1;
      chk("reset_outs", 64'({tck, tms, tdi, trst, bus.cmd_ready, bus.rsp_valid, bus.rsp_err}),
          64'(7'b0100000));
      chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
      sb.push_back(init_e);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("trst_release", 64'(trst), 64'd1);
      chk("ready_in_init", 64'(bus.cmd_ready), 64'd0);

      // loopback directed cases
      dly = 0;
      send(2'b10, 6'd8, 32'hA5);
      send(2'b01, 6'd4, 32'hF);
      send(2'b10, 6'd0, 32'hFFFF_FFFF);
      send(2'b11, 6'd3, 32'hDEAD_BEEF);
      send(2'b10, 6'd33, 32'h1234_5678);
      send(2'b00, 6'd42, 32'hCAFE_F00D);
      send(2'b10, 6'd32, 32'h8000_0001);
      drain();

      // 3-bit delay chain partner
      dly = 3; sr = '0; chain_c = '0;
      send(2'b10, 6'd16, 32'h3C5A);
      send(2'b10, 6'd16, 32'h3C5A);
      for (int i = 0; i < 30; i++) rand_cmd();
      drain();

      // abort during shift bit 5 of a 20-bit DR scan
      dly = 0;
      send(2'b10, 6'd20, $urandom);
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = (tap == SHDR);
      end
      n0 = ntck_total;
      for (int i = 0; i < 200 && ntck_total < n0 + 5; i++) @(negedge clk);
      chk("abort_reached_shift", 64'(ntck_total - n0), 64'd5);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_outs", 64'({tck, tms, tdi, trst, bus.cmd_ready, bus.rsp_valid, bus.rsp_err}),
          64'(7'b0100000));
      if (sb.size() != 0) void'(sb.pop_back());
      repeat (3) @(negedge clk);
      sb.push_back(init_e);
      reset = 1'b1;
      send(2'b10, 6'd12, $urandom);
      send(2'b01, 6'd5, $urandom);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
